// File: rtl/count_sequence_checker.sv
// rtl/count_sequence_checker.sv - samples counter code on strobe falls, decodes Gray, checks +1 sequence
// Tracks sequence lock and keeps a saturating count of breaks seen while locked.
module count_sequence_checker #(
  parameter int WIDTH      = 3,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_CNT_W  = 4
) (
  input  logic                 iCLOCK,
  input  logic                 iRESET,
  input  logic                 iSTROBE,
  input  logic                 iM,
  input  logic [WIDTH-1:0]     iCODE,
  output logic [WIDTH-1:0]     oBINARY,
  output logic                 oVALID,
  output logic                 oERROR,
  output logic                 oLOCKED,
  output logic [1:0]           oSTATE,
  output logic [ERR_CNT_W-1:0] oERRCOUNT
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ACQUIRE = 2'b01,
    S_LOCKED  = 2'b10
  } state_t;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_strobe_d;
  logic [WIDTH-1:0]     r_prev;
  logic                 r_prev_m;
  logic [3:0]           r_good_run;
  logic [3:0]           w_good_run_next;
  logic [3:0]           w_good_run_inc;
  logic [WIDTH-1:0]     r_binary;
  logic                 r_valid;
  logic                 r_error;
  logic                 w_error_next;
  logic [ERR_CNT_W-1:0] r_errcount;
  logic [ERR_CNT_W-1:0] w_errcount_next;
  logic                 w_sample;
  logic [WIDTH-1:0]     w_decoded;
  logic [WIDTH-1:0]     w_expected;
  logic                 w_mode_changed;
  logic                 w_match;
  logic                 w_repeat;

  // A sample needs the strobe to have been seen high on the previous edge.
  assign w_sample       = r_strobe_d & ~iSTROBE;
  assign w_expected     = r_prev + WIDTH'(1);
  assign w_mode_changed = (iM != r_prev_m);
  assign w_match        = (w_decoded == w_expected);
  assign w_repeat       = (w_decoded == r_prev);
  assign w_good_run_inc = r_good_run + 4'd1;

  always_comb begin
    w_decoded = iCODE;
    if (iM) begin
      for (int i = WIDTH - 2; i >= 0; i--) begin
        w_decoded[i] = w_decoded[i+1] ^ iCODE[i];
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_good_run_next = r_good_run;
    w_error_next    = 1'b0;
    w_errcount_next = r_errcount;
    if (w_sample) begin
      case (r_state)
        S_IDLE: begin
          w_state_next    = S_ACQUIRE;
          w_good_run_next = 4'd0;
        end
        S_ACQUIRE: begin
          if (w_mode_changed) begin
            w_good_run_next = 4'd0;
          end else if (w_match) begin
            w_good_run_next = w_good_run_inc;
            if (w_good_run_inc >= LOCK_TARGET) w_state_next = S_LOCKED;
          end else if (!w_repeat) begin
            w_good_run_next = 4'd0;
          end
        end
        S_LOCKED: begin
          if (w_mode_changed) begin
            w_state_next    = S_ACQUIRE;
            w_good_run_next = 4'd0;
          end else if (!w_match && !w_repeat) begin
            w_error_next    = 1'b1;
            w_state_next    = S_ACQUIRE;
            w_good_run_next = 4'd0;
            if (!(&r_errcount)) w_errcount_next = r_errcount + ERR_CNT_W'(1);
          end
        end
        default: begin
          w_state_next    = S_IDLE;
          w_good_run_next = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_state    <= S_IDLE;
      r_strobe_d <= 1'b0;
      r_prev     <= '0;
      r_prev_m   <= 1'b0;
      r_good_run <= 4'd0;
      r_binary   <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_errcount <= '0;
    end else begin
      r_state    <= w_state_next;
      r_strobe_d <= iSTROBE;
      r_good_run <= w_good_run_next;
      r_valid    <= w_sample;
      r_error    <= w_error_next;
      r_errcount <= w_errcount_next;
      if (w_sample) begin
        r_binary <= w_decoded;
        r_prev   <= w_decoded;
        r_prev_m <= iM;
      end
    end
  end

  assign oBINARY   = r_binary;
  assign oVALID    = r_valid;
  assign oERROR    = r_error;
  assign oLOCKED   = (r_state == S_LOCKED);
  assign oSTATE    = r_state;
  assign oERRCOUNT = r_errcount;

endmodule

// File: tb/tb_count_sequence_checker.sv
// tb/tb_count_sequence_checker.sv - directed vector bench for count_sequence_checker
module tb_count_sequence_checker;

  logic       iCLOCK = 1'b0;
  logic       iRESET = 1'b1;
  logic       iSTROBE = 1'b0;
  logic       iM = 1'b0;
  logic [2:0] iCODE = 3'd0;
  logic [2:0] oBINARY;
  logic       oVALID;
  logic       oERROR;
  logic       oLOCKED;
  logic [1:0] oSTATE;
  logic [3:0] oERRCOUNT;

  int tests = 0;
  int fails = 0;
  int err_pulses = 0;

  count_sequence_checker #(.WIDTH(3), .LOCK_COUNT(2), .ERR_CNT_W(4)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iSTROBE(iSTROBE), .iM(iM), .iCODE(iCODE),
    .oBINARY(oBINARY), .oVALID(oVALID), .oERROR(oERROR), .oLOCKED(oLOCKED),
    .oSTATE(oSTATE), .oERRCOUNT(oERRCOUNT)
  );

  always #5 iCLOCK = ~iCLOCK;

  always @(negedge iCLOCK) if (oERROR) err_pulses <= err_pulses + 1;

  typedef struct {
    logic [2:0] code;
    logic       m;
    logic [2:0] bin;
    logic       err;
    logic [1:0] state;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] bin, input logic valid,
                           input logic err, input logic [1:0] state, input logic [3:0] cnt);
    chk({tag, " binary"}, oBINARY, bin);
    chk({tag, " valid"}, oVALID, valid);
    chk({tag, " error"}, oERROR, err);
    chk({tag, " state"}, oSTATE, state);
    chk({tag, " locked"}, oLOCKED, (state == 2'b10));
    chk({tag, " errcount"}, oERRCOUNT, cnt);
  endtask

  task automatic do_sample(input string tag, input logic [2:0] code, input logic m,
                           input logic [2:0] bin, input logic err,
                           input logic [1:0] state, input logic [3:0] cnt);
    @(negedge iCLOCK);
    iSTROBE = 1'b1; iCODE = code; iM = m;
    @(negedge iCLOCK);
    iSTROBE = 1'b0;
    @(posedge iCLOCK); #1;
    check_all(tag, bin, 1'b1, err, state, cnt);
    @(posedge iCLOCK); #1;
    chk({tag, " valid width"}, oVALID, 0);
    chk({tag, " error width"}, oERROR, 0);
  endtask

  function automatic void add(input logic [2:0] code, input logic m, input logic [2:0] bin,
                              input logic err, input logic [1:0] state, input logic [3:0] cnt);
    vec_t v;
    v.code = code; v.m = m; v.bin = bin; v.err = err; v.state = state; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int prev;
    int v;
    int pulses0;

    // binary run 0..7,0,1
    add(3'd0, 0, 3'd0, 0, 2'b01, 0);
    add(3'd1, 0, 3'd1, 0, 2'b01, 0);
    add(3'd2, 0, 3'd2, 0, 2'b10, 0);
    add(3'd3, 0, 3'd3, 0, 2'b10, 0);
    add(3'd4, 0, 3'd4, 0, 2'b10, 0);
    add(3'd5, 0, 3'd5, 0, 2'b10, 0);
    add(3'd6, 0, 3'd6, 0, 2'b10, 0);
    add(3'd7, 0, 3'd7, 0, 2'b10, 0);
    add(3'd0, 0, 3'd0, 0, 2'b10, 0);
    add(3'd1, 0, 3'd1, 0, 2'b10, 0);
    // Gray run; mode change forces reacquire
    add(3'b000, 1, 3'd0, 0, 2'b01, 0);
    add(3'b001, 1, 3'd1, 0, 2'b01, 0);
    add(3'b011, 1, 3'd2, 0, 2'b10, 0);
    add(3'b010, 1, 3'd3, 0, 2'b10, 0);
    add(3'b110, 1, 3'd4, 0, 2'b10, 0);
    add(3'b111, 1, 3'd5, 0, 2'b10, 0);
    add(3'b101, 1, 3'd6, 0, 2'b10, 0);
    add(3'b100, 1, 3'd7, 0, 2'b10, 0);
    add(3'b000, 1, 3'd0, 0, 2'b10, 0);
    // binary skip while locked
    add(3'd1, 0, 3'd1, 0, 2'b01, 0);
    add(3'd2, 0, 3'd2, 0, 2'b01, 0);
    add(3'd3, 0, 3'd3, 0, 2'b10, 0);
    add(3'd5, 0, 3'd5, 1, 2'b01, 1);
    add(3'd6, 0, 3'd6, 0, 2'b01, 1);
    add(3'd7, 0, 3'd7, 0, 2'b10, 1);
    // locked Gray, switch to binary, counter stall, relock, repeat while locked
    add(3'b000, 1, 3'd0, 0, 2'b01, 1);
    add(3'b001, 1, 3'd1, 0, 2'b01, 1);
    add(3'b011, 1, 3'd2, 0, 2'b10, 1);
    add(3'b010, 1, 3'd3, 0, 2'b10, 1);
    add(3'd4, 0, 3'd4, 0, 2'b01, 1);
    add(3'd0, 0, 3'd0, 0, 2'b01, 1);
    add(3'd0, 0, 3'd0, 0, 2'b01, 1);
    add(3'd0, 0, 3'd0, 0, 2'b01, 1);
    add(3'd1, 0, 3'd1, 0, 2'b01, 1);
    add(3'd2, 0, 3'd2, 0, 2'b10, 1);
    add(3'd2, 0, 3'd2, 0, 2'b10, 1);

    #10;
    #1;
    check_all("reset", 3'd0, 1'b0, 1'b0, 2'b00, 4'd0);
    @(negedge iCLOCK);
    iRESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      do_sample($sformatf("vec%0d", i), vecs[i].code, vecs[i].m, vecs[i].bin,
                vecs[i].err, vecs[i].state, vecs[i].cnt);
    end

    // saturation: 20 forced breaks, each followed by a relock
    pulses0 = err_pulses;
    cnt = 1;
    prev = 2;
    for (int i = 0; i < 20; i++) begin
      v = (prev + 2) % 8;
      cnt = (cnt < 15) ? cnt + 1 : 15;
      do_sample($sformatf("sat%0d brk", i), 3'(v), 0, 3'(v), 1, 2'b01, 4'(cnt));
      do_sample($sformatf("sat%0d g1", i), 3'((v + 1) % 8), 0, 3'((v + 1) % 8), 0, 2'b01, 4'(cnt));
      do_sample($sformatf("sat%0d g2", i), 3'((v + 2) % 8), 0, 3'((v + 2) % 8), 0, 2'b10, 4'(cnt));
      prev = (v + 2) % 8;
    end
    chk("sat error pulses", err_pulses - pulses0, 20);
    chk("sat errcount final", oERRCOUNT, 15);

    // fresh reset, build errcount 3 while locked
    @(negedge iCLOCK); iRESET = 1'b1;
    @(negedge iCLOCK); iRESET = 1'b0;
    do_sample("r0", 3'd0, 0, 3'd0, 0, 2'b01, 0);
    do_sample("r1", 3'd1, 0, 3'd1, 0, 2'b01, 0);
    do_sample("r2", 3'd2, 0, 3'd2, 0, 2'b10, 0);
    do_sample("r3", 3'd4, 0, 3'd4, 1, 2'b01, 1);
    do_sample("r4", 3'd5, 0, 3'd5, 0, 2'b01, 1);
    do_sample("r5", 3'd6, 0, 3'd6, 0, 2'b10, 1);
    do_sample("r6", 3'd0, 0, 3'd0, 1, 2'b01, 2);
    do_sample("r7", 3'd1, 0, 3'd1, 0, 2'b01, 2);
    do_sample("r8", 3'd2, 0, 3'd2, 0, 2'b10, 2);
    do_sample("r9", 3'd4, 0, 3'd4, 1, 2'b01, 3);
    do_sample("r10", 3'd5, 0, 3'd5, 0, 2'b01, 3);
    do_sample("r11", 3'd6, 0, 3'd6, 0, 2'b10, 3);

    // async reset between edges; strobe high during reset is never observed
    #2;
    iSTROBE = 1'b1;
    iRESET = 1'b1;
    #1;
    check_all("async rst", 3'd0, 1'b0, 1'b0, 2'b00, 4'd0);
    @(negedge iCLOCK);
    iRESET = 1'b0;
    iSTROBE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge iCLOCK); #1;
      chk($sformatf("no sample valid %0d", i), oVALID, 0);
      chk($sformatf("no sample state %0d", i), oSTATE, 0);
    end
    do_sample("post0", 3'd3, 0, 3'd3, 0, 2'b01, 0);
    do_sample("post1", 3'd4, 0, 3'd4, 0, 2'b01, 0);
    do_sample("post2", 3'd5, 0, 3'd5, 0, 2'b10, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/count_sequence_checker.md
Name: count_sequence_checker

Overview:
Receive-side companion to the binary/Gray complex counter. It samples the counter's code output once per divided-clock period and decodes Gray to binary when the mode input selects it. It checks that every sample is the previous value plus one (mod 2^WIDTH), tracks sequence lock, and counts sequence errors. It sits downstream of the counter and provides self-checking and status.

Parameters:
WIDTH, 3, code width in bits
LOCK_COUNT, 2, consecutive good increments needed to enter LOCKED (range 1..15)
ERR_CNT_W, 4, width of the saturating error counter

Ports:
iCLOCK  input  1  system clock; all logic on posedge
iRESET  input  1  asynchronous, active-high reset
iSTROBE  input  1  divided clock from the counter; sampled synchronously on iCLOCK
iM  input  1  code mode: 0 = binary, 1 = Gray
iCODE  input  WIDTH  count code from the counter
oBINARY  output  WIDTH  last decoded sample (binary)
oVALID  output  1  one-cycle pulse: new sample decoded
oERROR  output  1  one-cycle pulse: sequence break detected while LOCKED
oLOCKED  output  1  high while state is LOCKED
oSTATE  output  2  FSM state: 00 IDLE, 01 ACQUIRE, 10 LOCKED
oERRCOUNT  output  ERR_CNT_W  saturating count of oERROR pulses

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; state IDLE; strobe history register 0; previous-sample, previous-mode and good-run registers 0. Reset takes effect immediately, independent of iCLOCK.
- Sample event:
  - Defined as an iCLOCK posedge where iSTROBE is 0 and the registered iSTROBE from the previous posedge is 1 (falling edge of iSTROBE, mid-period of the counter's cycle).
  - iSTROBE must stay high for at least one iCLOCK period before a fall is recognised.
  - On that edge, iCODE and iM are captured.
  - All outputs are registered and update on that same edge. Latency: 1 iCLOCK edge from the detected fall.
- Decode:
  - iM=0: value = iCODE.
  - iM=1: b[MSB] = g[MSB]; b[i] = b[i+1] XOR g[i].
  - oBINARY <= decoded value on every sample event; it holds otherwise.
- oVALID = 1 for exactly the one cycle following each sample event. oERROR is likewise one cycle wide.
- Comparison uses exp = prev + 1 mod 2^WIDTH, so wrap from all-ones to 0 is a match.
- FSM (evaluated only on sample events; no transitions between events):
  - IDLE: store sample and mode; go ACQUIRE; good_run = 0.
  - ACQUIRE, mode changed since previous sample: good_run = 0; stay ACQUIRE.
  - ACQUIRE, match: good_run + 1; if it reaches LOCK_COUNT, go LOCKED.
  - ACQUIRE, repeat (sample == prev): good_run unchanged; stay.
  - ACQUIRE, other mismatch: good_run = 0; stay. No oERROR.
  - LOCKED, match: stay.
  - LOCKED, repeat: stay. No error; this covers a counter held in reset.
  - LOCKED, mode changed: go ACQUIRE; good_run = 0. No oERROR (resync).
  - LOCKED, other mismatch: oERROR pulse; oERRCOUNT + 1 (saturates at all-ones, never wraps); go ACQUIRE; good_run = 0.
- Mode-change check takes priority over the match/mismatch check.
- Previous-sample and previous-mode registers update on every sample event.
- oERRCOUNT clears only on iRESET.

Test Plan:
- Reset then binary run: iRESET=1 for 10 ns, release; iM=0; iCODE 0,1,2,...,7,0,1 on successive iSTROBE falls -> oBINARY follows 0..7,0,1. oVALID pulses once per fall. oSTATE 00->01 after 1st sample; oLOCKED=1 after 3rd sample (LOCK_COUNT=2). Wrap 7->0 gives no oERROR; oERRCOUNT=0.
- Gray run: iM=1; iCODE 000,001,011,010,110,111,101,100,000 -> oBINARY 0,1,2,3,4,5,6,7,0. Locked from 3rd sample; no oERROR.
- Skip while locked: binary 1,2,3,5,6,7 -> single-cycle oERROR at sample "5"; oERRCOUNT=1; oLOCKED 1->0; oSTATE=01; relock at sample "7".
- Mode switch and stall: locked Gray stream, switch iM to 0 with iCODE=4 -> no oERROR, oSTATE=01. Then repeated 0,0,0 (counter reset) followed by 1,2 -> no errors, relock.
- Saturation: 20 forced mismatches, each preceded by enough good samples to relock -> oERRCOUNT stops at 15, oERROR still pulses 20 times.
- Async reset mid-operation: assert iRESET between iCLOCK edges while LOCKED with oERRCOUNT=3 -> all outputs 0 at once. After release, the first iSTROBE fall without a prior observed high gives no sample; normal acquisition follows.
